// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: instruction class encodings.
package pc_sequencer_pkg;

  localparam int PC_KIND_W = 3;

  typedef enum logic [PC_KIND_W-1:0] {
    PC_KIND_SEQ    = 3'd0,
    PC_KIND_JUMP   = 3'd1,
    PC_KIND_CALL   = 3'd2,
    PC_KIND_RET    = 3'd3,
    PC_KIND_BRANCH = 3'd4,
    PC_KIND_JREG   = 3'd5
  } pc_kind_e;

  // Unassigned encodings behave as plain sequential instructions.
  function automatic pc_kind_e decode_kind(input logic [PC_KIND_W-1:0] raw);
    pc_kind_e k;
    case (raw)
      3'd1:    k = PC_KIND_JUMP;
      3'd2:    k = PC_KIND_CALL;
      3'd3:    k = PC_KIND_RET;
      3'd4:    k = PC_KIND_BRANCH;
      3'd5:    k = PC_KIND_JREG;
      default: k = PC_KIND_SEQ;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack; ptr addresses the top entry, count saturates at DEPTH.
// Push on full overwrites the oldest entry; pop on empty returns the stale top and still moves ptr.
module pc_return_stack #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  input  logic              restore,
  input  logic [PTR_W-1:0]  restore_ptr,
  input  logic [CNT_W-1:0]  restore_count,
  output logic [ADDR_W-1:0] top,
  output logic [PTR_W-1:0]  ptr,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] entries [DEPTH];
  logic              full;
  logic              empty;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign top       = entries[ptr];
  assign overflow  = push && !restore && full;
  assign underflow = pop && !restore && !push && empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (restore) begin
      ptr   <= restore_ptr;
      count <= restore_count;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop) begin
      ptr <= ptr - PTR_W'(1);
      if (!empty) count <= count - CNT_W'(1);
    end
  end

  // Entry storage carries no reset so a pop on empty sees whatever was left behind.
  always_ff @(posedge clk) begin
    if (!reset && !restore && push) entries[ptr + PTR_W'(1)] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC generator: sequential/jump/call/return plus predict-not-taken branches and jump-register,
// resolved after fixed latencies through tracking pipes that squash younger work on redirect.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                RAS_DEPTH = 8,
  parameter int                BR_LAT    = 2,
  parameter int                JR_LAT    = 1,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 keep_pc,
  input  logic [PC_KIND_W-1:0] dec_kind,
  input  logic [ADDR_W-1:0]    dec_target,
  input  logic [ADDR_W-1:0]    rs,
  input  logic                 branch_taken,
  output logic [ADDR_W-1:0]    pc,
  output logic                 flush,
  output logic                 ras_overflow,
  output logic                 ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // Branch tracking pipe: stage BR_LAT-1 is the oldest entry, resolved against branch_taken.
  logic              br_vld [BR_LAT];
  logic [ADDR_W-1:0] br_tgt [BR_LAT];
  logic [PTR_W-1:0]  br_ptr [BR_LAT];
  logic [CNT_W-1:0]  br_cnt [BR_LAT];
  logic              jr_vld [JR_LAT];

  logic [ADDR_W-1:0] ras_top;
  logic [PTR_W-1:0]  ras_ptr;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_ovf_pulse;
  logic              ras_unf_pulse;

  pc_kind_e          kind;
  logic              br_fire;
  logic              jr_fire;
  logic              redirect;
  logic              accept;
  logic              ras_push;
  logic              ras_pop;
  logic              br_in;
  logic              jr_in;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;

  assign kind     = decode_kind(dec_kind);
  assign pc_inc   = pc + ADDR_W'(1);
  assign br_fire  = br_vld[BR_LAT-1] && branch_taken;
  assign jr_fire  = jr_vld[JR_LAT-1];
  assign redirect = br_fire || jr_fire;
  assign accept   = !redirect && !keep_pc;
  assign ras_push = accept && (kind == PC_KIND_CALL);
  assign ras_pop  = accept && (kind == PC_KIND_RET);
  assign br_in    = accept && (kind == PC_KIND_BRANCH);
  assign jr_in    = accept && (kind == PC_KIND_JREG);

  // The branch tail is always older than the JREG tail, so it wins a simultaneous resolve.
  always_comb begin
    pc_next = pc;
    if (br_fire) begin
      pc_next = br_tgt[BR_LAT-1];
    end else if (jr_fire) begin
      pc_next = rs;
    end else if (!keep_pc) begin
      case (kind)
        PC_KIND_JUMP: pc_next = dec_target;
        PC_KIND_CALL: pc_next = dec_target;
        PC_KIND_RET:  pc_next = ras_top;
        default:      pc_next = pc_inc;
      endcase
    end
  end

  pc_return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk           (clk),
    .reset         (reset),
    .push          (ras_push),
    .pop           (ras_pop),
    .push_data     (pc_inc),
    .restore       (br_fire),
    .restore_ptr   (br_ptr[BR_LAT-1]),
    .restore_count (br_cnt[BR_LAT-1]),
    .top           (ras_top),
    .ptr           (ras_ptr),
    .count         (ras_count),
    .overflow      (ras_ovf_pulse),
    .underflow     (ras_unf_pulse)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      flush         <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_next;
      flush         <= redirect;
      ras_overflow  <= ras_overflow | ras_ovf_pulse;
      ras_underflow <= ras_underflow | ras_unf_pulse;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      for (int i = 0; i < BR_LAT; i++) br_vld[i] <= 1'b0;
      for (int i = 0; i < JR_LAT; i++) jr_vld[i] <= 1'b0;
    end else begin
      br_vld[0] <= br_in;
      br_tgt[0] <= dec_target;
      br_ptr[0] <= ras_ptr;
      br_cnt[0] <= ras_count;
      for (int i = 1; i < BR_LAT; i++) begin
        br_vld[i] <= br_vld[i-1];
        br_tgt[i] <= br_tgt[i-1];
        br_ptr[i] <= br_ptr[i-1];
        br_cnt[i] <= br_cnt[i-1];
      end
      jr_vld[0] <= jr_in;
      for (int i = 1; i < JR_LAT; i++) jr_vld[i] <= jr_vld[i-1];
    end
  end

endmodule
